// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg: shared debounce constants and counter-width helper
// Items:
//   DEBOUNCE_DEFAULT - default stable-cycle count (20 ms at 50 MHz)
//   cnt_width()      - counter width able to hold 0..cycles
//   DEBOUNCE_CNT_W   - counter width for the default count
package switch_conditioner_pkg;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
  localparam int DEBOUNCE_CNT_W = cnt_width(DEBOUNCE_DEFAULT);
endpackage

// File: rtl/switch_conditioner_channel.sv
// debounce_channel: one switch channel -- synchronizer, stability counter, level and edge pulses
// Ports:
//   clock   - rising-edge system clock
//   reset_n - synchronous active-low reset
//   raw_i   - asynchronous switch level
//   level_o - debounced stable level
//   rise_o  - one-cycle pulse on an accepted 0->1 change
//   fall_o  - one-cycle pulse on an accepted 1->0 change
module debounce_channel
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, level_q, level_d, rise_q, rise_d, fall_q, fall_d, differ, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  // The counter only runs while the synchronized input disagrees with level,
  // so it saturates at LAST and acceptance clears it.
  always_comb begin
    differ  = sync2_q ^ level_q;
    accept  = differ && (cnt_q == LAST);
    cnt_d   = (differ && !accept) ? cnt_q + CW'(1) : '0;
    level_d = accept ? sync2_q : level_q;
    rise_d  = accept & sync2_q;
    fall_d  = accept & ~sync2_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: WIDTH independent debounced switch channels with edge pulses
// Ports:
//   clock   - rising-edge system clock
//   reset_n - synchronous active-low reset
//   raw     - asynchronous switch/key levels
//   level   - debounced stable levels
//   rise    - per-channel one-cycle pulse on accepted 0->1
//   fall    - per-channel one-cycle pulse on accepted 1->0
//   changed - OR of all rise and fall bits
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .raw_i   (raw[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end
  assign changed = |(rise | fall);
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and randomized checks of switch_conditioner against a history-window model
module tb_switch_conditioner;
  localparam int W = 4;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, rise, fall;
  logic changed;
  int chk_cnt = 0;
  int err_cnt = 0;
  int rise_cnt [W];
  int fall_cnt [W];
  bit chk_en = 1'b0;
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_level = '0, m_rise = '0, m_fall = '0;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (raw),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  always #5 clock = ~clock;

  // Model: hist[k] is raw as sampled k+1 edges ago, so hist[1] is what the
  // design sees after two flops. A change is accepted when the last D
  // synchronized samples all disagree with the current level.
  always @(posedge clock) begin : model
    logic [W-1:0] nl, r, f;
    bit st;
    nl = m_level;
    r = '0;
    f = '0;
    if (!reset_n) nl = '0;
    else
      for (int c = 0; c < W; c++) begin
        st = 1'b1;
        for (int j = 0; j < D; j++) if (hist[j+1][c] == m_level[c]) st = 1'b0;
        if (st) begin
          nl[c] = ~m_level[c];
          r[c] = ~m_level[c];
          f[c] = m_level[c];
        end
      end
    m_level <= nl;
    m_rise <= r;
    m_fall <= f;
    hist[0] <= reset_n ? raw : '0;
    for (int k = 1; k <= D; k++) hist[k] <= reset_n ? hist[k-1] : '0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] += int'(rise[i]);
      fall_cnt[i] += int'(fall[i]);
    end
    if (chk_en) begin
      check("model_level", 32'(level), 32'(m_level));
      check("model_rise", 32'(rise), 32'(m_rise));
      check("model_fall", 32'(fall), 32'(m_fall));
      check("model_changed", 32'(changed), 32'(|(m_rise | m_fall)));
      check("rise_and_fall", 32'(rise & fall), 32'd0);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    raw = '0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    raw = 4'b1111;
    repeat (3) tick();
    chk_en = 1'b1;
    // reset with all inputs high, then release
    repeat (3) begin
      tick();
      check("rst_level", 32'(level), 32'd0);
      check("rst_rise", 32'(rise), 32'd0);
    end
    reset_n = 1'b1;
    repeat (5) tick();
    check("rel_rise_early", 32'(rise), 32'd0);
    tick();
    check("rel_rise", 32'(rise), 32'hf);
    check("rel_level", 32'(level), 32'hf);
    check("rel_changed", 32'(changed), 32'd1);
    tick();
    check("rel_rise_once", 32'(rise), 32'd0);
    // glitch rejection: three cycles high is one short
    do_reset(2);
    base = rise_cnt[0];
    raw[0] = 1'b1;
    repeat (3) tick();
    raw[0] = 1'b0;
    repeat (15) tick();
    check("glitch_level", 32'(level[0]), 32'd0);
    check("glitch_rise", 32'(rise_cnt[0] - base), 32'd0);
    // clean fall
    do_reset(2);
    raw = 4'b0001;
    repeat (10) tick();
    check("fall_pre_level", 32'(level), 32'h1);
    base = fall_cnt[0];
    raw[0] = 1'b0;
    repeat (5) tick();
    check("fall_early", 32'(fall), 32'd0);
    tick();
    check("fall_pulse", 32'(fall), 32'h1);
    check("fall_level", 32'(level), 32'd0);
    repeat (10) tick();
    check("fall_once", 32'(fall_cnt[0] - base), 32'd1);
    // bounce on channel 1, then settle high
    do_reset(2);
    base = rise_cnt[1];
    for (int t = 0; t < 20; t++) begin
      raw[1] = ((t / 2) % 2) == 0;
      tick();
    end
    check("bounce_quiet", 32'(rise_cnt[1] - base), 32'd0);
    raw[1] = 1'b1;
    repeat (5) tick();
    check("bounce_early", 32'(rise[1]), 32'd0);
    tick();
    check("bounce_rise", 32'(rise), 32'h2);
    repeat (10) tick();
    check("bounce_once", 32'(rise_cnt[1] - base), 32'd1);
    // reset while channel 3 counter is at 2
    do_reset(2);
    raw[3] = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    repeat (2) begin
      tick();
      check("mid_rst_rise", 32'(rise), 32'd0);
    end
    reset_n = 1'b1;
    repeat (5) tick();
    check("mid_early", 32'(rise), 32'd0);
    tick();
    check("mid_rise", 32'(rise), 32'h8);
    // channel independence
    do_reset(2);
    raw[1] = 1'b1;
    repeat (2) tick();
    raw[2] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("indep_rise", 32'(rise), t == 4 ? 32'h2 : (t == 6 ? 32'h4 : 32'h0));
    end
    // randomized traffic with occasional resets
    do_reset(2);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      raw = raw ^ W'($urandom & $urandom);
      repeat ($urandom_range(1, 8)) tick();
    end
    reset_n = 1'b1;
    repeat (10) tick();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
